// File: rtl/roach_rst_seq_pkg.sv
// Shared state encoding, widths and small helpers for the ROACH reset sequencer.
package roach_rst_seq_pkg;

    localparam int LOCK_LOSS_CNT_W = 16;
    localparam int RETRY_CNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_LOCK_STABLE = 3'd2,
        ST_IDLY_RST    = 3'd3,
        ST_WAIT_RDY    = 3'd4,
        ST_HOLD        = 3'd5,
        ST_RUN         = 3'd6,
        ST_FAULT       = 3'd7
    } state_t;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // IDELAYCTRL is held in reset until lock is confirmed, then pulsed once per attempt.
    function automatic logic idelay_rst_of(input state_t s);
        return (s == ST_IDLE) || (s == ST_WAIT_LOCK) || (s == ST_IDLY_RST);
    endfunction

endpackage

// File: rtl/roach_rst_seq_sync.sv
// Per-bit two-flop synchroniser with asynchronous active-low clear.
module roach_rst_seq_sync #(
    parameter int WIDTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [1:0] r_chain;
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) r_chain <= 2'b00;
                else          r_chain <= {r_chain[0], i_d[gi]};
            end
            assign o_q[gi] = r_chain[1];
        end
    endgenerate

endmodule

// File: rtl/roach_rst_sequencer.sv
// Clock/IDELAY bring-up sequencer: waits for stable lock, pulses idelay_rst, then releases user_rst.
// Optional saturating lock-loss counter enabled by ROACH_RST_SEQ_LOCK_LOSS_CNT_EN.
module roach_rst_sequencer
    import roach_rst_seq_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int IDELAY_RST_CYCLES  = 64,
    parameter int RDY_TIMEOUT        = 4096,
    parameter int MAX_RETRY          = 3,
    parameter int USER_RST_HOLD      = 16
) (
    input  logic                       sys_clk,
    input  logic                       rst_n,
    input  logic                       sys_clk_lock,
    input  logic                       op_power_on_rst,
    input  logic                       idelay_rdy,
    input  logic                       clear_fault,
    output logic                       idelay_rst,
    output logic                       user_rst,
    output logic                       ready,
    output logic                       fault,
    output logic [2:0]                 state,
    output logic [RETRY_CNT_W-1:0]     retry_cnt,
    output logic [LOCK_LOSS_CNT_W-1:0] lock_loss_cnt
);

    localparam int CNT_MAX = max4(LOCK_STABLE_CYCLES, IDELAY_RST_CYCLES, RDY_TIMEOUT, USER_RST_HOLD);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]       LS_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]       IR_LAST   = CNT_W'(IDELAY_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]       TO_LAST   = CNT_W'(RDY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]       HOLD_LAST = CNT_W'(USER_RST_HOLD - 1);
    localparam logic [RETRY_CNT_W-1:0] RETRY_LIM = RETRY_CNT_W'(MAX_RETRY);

    logic [2:0]             w_sync;
    logic                   w_lock;
    logic                   w_por;
    logic                   w_rdy;
    logic                   w_in_bringup;
    logic                   w_abort;
    state_t                 w_state_next;
    logic [CNT_W-1:0]       w_cnt_next;
    logic [RETRY_CNT_W-1:0] w_retry_next;

    state_t                 r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [RETRY_CNT_W-1:0] r_retry_cnt;
    logic                   r_idelay_rst;
    logic                   r_user_rst;
    logic                   r_ready;
    logic                   r_fault;

    roach_rst_seq_sync #(
        .WIDTH (3)
    ) u_sync (
        .i_clk   (sys_clk),
        .i_rst_n (rst_n),
        .i_d     ({idelay_rdy, op_power_on_rst, sys_clk_lock}),
        .o_q     (w_sync)
    );

    assign w_lock = w_sync[0];
    assign w_por  = w_sync[1];
    assign w_rdy  = w_sync[2];

    // Lock loss / POR outranks every in-progress count from LOCK_STABLE through RUN; FAULT is sticky.
    assign w_in_bringup = (r_state >= ST_LOCK_STABLE) && (r_state <= ST_RUN);
    assign w_abort      = w_in_bringup && (!w_lock || w_por);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_retry_next = r_retry_cnt;
        if (w_abort) begin
            w_state_next = ST_WAIT_LOCK;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: w_state_next = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (w_lock && !w_por) begin
                        w_state_next = ST_LOCK_STABLE;
                        w_cnt_next   = '0;
                    end
                end
                ST_LOCK_STABLE: begin
                    if (r_cnt == LS_LAST) begin
                        w_state_next = ST_IDLY_RST;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_IDLY_RST: begin
                    if (r_cnt == IR_LAST) begin
                        w_state_next = ST_WAIT_RDY;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_WAIT_RDY: begin
                    if (w_rdy) begin
                        w_state_next = ST_HOLD;
                        w_cnt_next   = '0;
                    end else if (r_cnt == TO_LAST) begin
                        w_cnt_next = '0;
                        if (r_retry_cnt < RETRY_LIM) begin
                            w_retry_next = r_retry_cnt + 1'b1;
                            w_state_next = ST_IDLY_RST;
                        end else begin
                            w_state_next = ST_FAULT;
                        end
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_state_next = ST_RUN;
                        w_cnt_next   = '0;
                        w_retry_next = '0;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end
                ST_RUN: w_state_next = ST_RUN;
                ST_FAULT: begin
                    if (clear_fault) begin
                        w_state_next = ST_WAIT_LOCK;
                        w_cnt_next   = '0;
                        w_retry_next = '0;
                    end
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so they change on the same edge as state.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_retry_cnt  <= '0;
            r_idelay_rst <= 1'b1;
            r_user_rst   <= 1'b1;
            r_ready      <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_retry_cnt  <= w_retry_next;
            r_idelay_rst <= idelay_rst_of(w_state_next);
            r_user_rst   <= (w_state_next != ST_RUN);
            r_ready      <= (w_state_next == ST_RUN);
            r_fault      <= (w_state_next == ST_FAULT);
        end
    end

    assign state      = r_state;
    assign retry_cnt  = r_retry_cnt;
    assign idelay_rst = r_idelay_rst;
    assign user_rst   = r_user_rst;
    assign ready      = r_ready;
    assign fault      = r_fault;

`ifdef ROACH_RST_SEQ_LOCK_LOSS_CNT_EN
    logic [LOCK_LOSS_CNT_W-1:0] r_lock_loss_cnt;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_loss_cnt <= '0;
        end else if (w_in_bringup && !w_lock && (r_lock_loss_cnt != '1)) begin
            r_lock_loss_cnt <= r_lock_loss_cnt + 1'b1;
        end
    end

    assign lock_loss_cnt = r_lock_loss_cnt;
`else
    assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_roach_rst_sequencer.sv
// Randomised bring-up scenarios; expected state events are queued by stimulus and checked by a monitor.
module tb_roach_rst_sequencer;

    localparam int LSC = 8;
    localparam int IRC = 4;
    localparam int RT  = 16;
    localparam int MR  = 2;
    localparam int URH = 2;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WL    = 3'd1;
    localparam logic [2:0] S_LS    = 3'd2;
    localparam logic [2:0] S_IR    = 3'd3;
    localparam logic [2:0] S_WR    = 3'd4;
    localparam logic [2:0] S_HOLD  = 3'd5;
    localparam logic [2:0] S_RUN   = 3'd6;
    localparam logic [2:0] S_FAULT = 3'd7;

`ifdef ROACH_RST_SEQ_LOCK_LOSS_CNT_EN
    localparam int LLC_INC = 1;
`else
    localparam int LLC_INC = 0;
`endif

    logic        sys_clk = 1'b0;
    logic        rst_n   = 1'b0;
    logic        lock    = 1'b0;
    logic        por     = 1'b0;
    logic        rdy     = 1'b0;
    logic        clr     = 1'b0;
    logic        idelay_rst;
    logic        user_rst;
    logic        ready;
    logic        fault;
    logic [2:0]  state;
    logic [3:0]  retry_cnt;
    logic [15:0] lock_loss_cnt;

    typedef struct {
        logic [2:0] st;
        int         dwell;
        int         retry;
        int         llc;
    } exp_t;

    exp_t exp_q[$];
    int   total   = 0;
    int   bad     = 0;
    int   cyc     = 0;
    int   exp_llc = 0;
    int   pulses  = 0;

    roach_rst_sequencer #(
        .LOCK_STABLE_CYCLES (LSC),
        .IDELAY_RST_CYCLES  (IRC),
        .RDY_TIMEOUT        (RT),
        .MAX_RETRY          (MR),
        .USER_RST_HOLD      (URH)
    ) dut (
        .sys_clk         (sys_clk),
        .rst_n           (rst_n),
        .sys_clk_lock    (lock),
        .op_power_on_rst (por),
        .idelay_rdy      (rdy),
        .clear_fault     (clr),
        .idelay_rst      (idelay_rst),
        .user_rst        (user_rst),
        .ready           (ready),
        .fault           (fault),
        .state           (state),
        .retry_cnt       (retry_cnt),
        .lock_loss_cnt   (lock_loss_cnt)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endfunction

    function automatic void push(input logic [2:0] st, input int dwell, input int retry);
        exp_t e;
        e.st    = st;
        e.dwell = dwell;
        e.retry = retry;
        e.llc   = exp_llc;
        exp_q.push_back(e);
    endfunction

    // Expected events from IDLY_RST entry: r timeouts, then rdy after j cycles (or fault when fault_end).
    function automatic void push_bringup(input int r, input int j, input bit fault_end);
        int n;
        push(S_IR, LSC, 0);
        push(S_WR, IRC, 0);
        n = fault_end ? MR : r;
        for (int i = 1; i <= n; i++) begin
            push(S_IR, RT, i);
            push(S_WR, IRC, i);
        end
        if (fault_end) begin
            push(S_FAULT, RT, MR);
        end else begin
            push(S_HOLD, j + 3, r);
            push(S_RUN, URH, 0);
        end
    endfunction

    task automatic wait_state(input logic [2:0] s, input int budget);
        int n = 0;
        while (state !== s && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        total++;
        if (state !== s) begin
            bad++;
            $display("FAIL wait_state: got state %0d, required %0d within %0d cycles", state, s, budget);
        end
    endtask

    task automatic drive_rdy(input int r, input int j);
        for (int i = 0; i <= r; i++) begin
            wait_state(S_WR, 200);
            if (i < r) wait_state(S_IR, 100);
        end
        repeat (j) @(negedge sys_clk);
        rdy = 1'b1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, state, S_IDLE);
        chk({tag, "_idelay_rst"}, idelay_rst, 1);
        chk({tag, "_user_rst"}, user_rst, 1);
        chk({tag, "_ready"}, ready, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_retry_cnt"}, retry_cnt, 0);
        chk({tag, "_lock_loss_cnt"}, lock_loss_cnt, 0);
    endtask

    // Monitor: each observed state change pops one expectation.
    initial begin
        logic [2:0] last_st;
        int         last_t;
        logic       prev_idr;
        exp_t       e;
        last_st  = S_IDLE;
        last_t   = 0;
        prev_idr = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (!rst_n) begin
                last_st  = S_IDLE;
                last_t   = cyc;
                prev_idr = 1'b1;
            end else begin
                if (idelay_rst && !prev_idr) pulses++;
                prev_idr = idelay_rst;
                if (state !== last_st) begin
                    $display("event: cycle=%0d state %0d -> %0d after %0d cycles retry=%0d llc=%0d",
                             cyc, last_st, state, cyc - last_t, retry_cnt, lock_loss_cnt);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_event: got state %0d, required no change from %0d", state, last_st);
                    end else begin
                        e = exp_q.pop_front();
                        chk("state", state, e.st);
                        if (e.dwell >= 0) chk("dwell", cyc - last_t, e.dwell);
                        chk("retry_cnt", retry_cnt, e.retry);
                        chk("lock_loss_cnt", lock_loss_cnt, e.llc);
                        chk("idelay_rst", idelay_rst, (e.st == S_IDLE || e.st == S_WL || e.st == S_IR));
                        chk("user_rst", user_rst, (e.st != S_RUN));
                        chk("ready", ready, (e.st == S_RUN));
                        chk("fault", fault, (e.st == S_FAULT));
                    end
                    last_st = state;
                    last_t  = cyc;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int r;
        int j;
        int g;

        repeat (4) @(negedge sys_clk);
        chk_reset_values("por_reset");

        // Normal bring-up: lock raised 5 cycles after reset release
        push(S_WL, -1, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge sys_clk);
        j = $urandom_range(0, 10);
        push(S_LS, -1, 0);
        push_bringup(0, j, 1'b0);
        lock = 1'b1;
        drive_rdy(0, j);
        wait_state(S_RUN, 100);
        chk("run_ready", ready, 1);
        chk("run_retry", retry_cnt, 0);

        // Lock loss in RUN: reaction on the third edge after the raw drop
        repeat ($urandom_range(1, 5)) @(negedge sys_clk);
        exp_llc += LLC_INC;
        push(S_WL, -1, 0);
        lock = 1'b0;
        rdy  = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk("lockloss_ready_2cyc", ready, 1);
        @(negedge sys_clk);
        chk("lockloss_user_rst", user_rst, 1);
        chk("lockloss_ready", ready, 0);

        // Lock glitch during LOCK_STABLE, then random retries before rdy
        repeat (3) @(negedge sys_clk);
        push(S_LS, -1, 0);
        lock = 1'b1;
        wait_state(S_LS, 20);
        g = $urandom_range(0, 4);
        r = $urandom_range(0, MR);
        j = $urandom_range(0, 10);
        exp_llc += LLC_INC;
        push(S_WL, g + 3, 0);
        push(S_LS, 1, 0);
        push_bringup(r, j, 1'b0);
        repeat (g) @(negedge sys_clk);
        lock = 1'b0;
        @(negedge sys_clk);
        lock = 1'b1;
        drive_rdy(r, j);
        wait_state(S_RUN, 400);

        // Timeout with retries into FAULT
        repeat (2) @(negedge sys_clk);
        exp_llc += LLC_INC;
        push(S_WL, -1, 0);
        lock = 1'b0;
        rdy  = 1'b0;
        repeat (4) @(negedge sys_clk);
        push(S_LS, -1, 0);
        push_bringup(0, 0, 1'b1);
        lock = 1'b1;
        wait_state(S_LS, 20);
        pulses = 0;
        wait_state(S_FAULT, 400);
        chk("fault_pulses", pulses, MR + 1);
        chk("fault_flag", fault, 1);
        chk("fault_retry", retry_cnt, MR);
        chk("fault_user_rst", user_rst, 1);

        // Lock loss inside FAULT is ignored
        lock = 1'b0;
        repeat (6) @(negedge sys_clk);
        lock = 1'b1;
        repeat (6) @(negedge sys_clk);
        chk("fault_sticky_state", state, S_FAULT);

        // Fault recovery
        j = $urandom_range(0, 10);
        push(S_WL, -1, 0);
        push(S_LS, 1, 0);
        push_bringup(0, j, 1'b0);
        clr = 1'b1;
        @(negedge sys_clk);
        clr = 1'b0;
        drive_rdy(0, j);
        wait_state(S_RUN, 100);
        chk("recover_retry", retry_cnt, 0);
        chk("recover_ready", ready, 1);

        // POR in RUN, then asynchronous reset mid-WAIT_RDY
        repeat (3) @(negedge sys_clk);
        push(S_WL, -1, 0);
        push(S_LS, -1, 0);
        push(S_IR, LSC, 0);
        push(S_WR, IRC, 0);
        por = 1'b1;
        rdy = 1'b0;
        repeat (2) @(negedge sys_clk);
        por = 1'b0;
        wait_state(S_WR, 100);
        repeat (3) @(negedge sys_clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_values("async_reset");
        chk("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge sys_clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/roach_rst_sequencer.md
Name: roach_rst_sequencer

Overview:
- Consumer-side controller for the board clock/reset infrastructure block. It watches `sys_clk_lock` and `op_power_on_rst`, pulses `idelay_rst`, and waits for `idelay_rdy` with a timeout and bounded retries.
- Once the clocking is stable, it releases a fabric reset (`user_rst`).
- It sits beside the infrastructure instance in the top-level system and drives that block's `idelay_rst` input.

Parameters:
- LOCK_STABLE_CYCLES, 1024: consecutive locked cycles required before IDELAY reset.
- IDELAY_RST_CYCLES, 64: width of the `idelay_rst` pulse, in `sys_clk` cycles.
- RDY_TIMEOUT, 4096: cycles to wait for `idelay_rdy` before a retry.
- MAX_RETRY, 3: IDELAY reset retries before entering FAULT (range 0..15).
- USER_RST_HOLD, 16: cycles `user_rst` stays high after `idelay_rdy` is seen.

Ports:
- sys_clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- sys_clk_lock  in  1  MMCM lock; asynchronous to `sys_clk`, synchronised internally.
- op_power_on_rst  in  1  power-on reset request, active-high, synchronised internally.
- idelay_rdy  in  1  IDELAYCTRL ready, synchronised internally.
- clear_fault  in  1  single-cycle pulse; leaves FAULT.
- idelay_rst  out  1  IDELAYCTRL reset, active-high.
- user_rst  out  1  fabric reset, active-high.
- ready  out  1  high only in RUN.
- fault  out  1  high only in FAULT.
- state  out  3  current state encoding, for a software register.
- retry_cnt  out  4  retries used in the current bring-up.
- lock_loss_cnt  out  16  saturating count of lock-loss events (only when the optional feature is enabled).

Behaviour:
- Reset (`rst_n`=0) values:
  - `state`=IDLE, `idelay_rst`=1, `user_rst`=1, `ready`=0, `fault`=0, `retry_cnt`=0, `lock_loss_cnt`=0.
  - All counters and synchroniser flops cleared.
- Input synchronisation:
  - `sys_clk_lock`, `op_power_on_rst` and `idelay_rdy` pass through 2-flop synchronisers.
  - The FSM sees them 2 cycles late. All references to `lock`, `por` and `rdy` below mean the synchronised versions.
- Outputs are registered, Moore-style from state and counters. `ready` is high exactly when `state`=RUN.
- State encoding: IDLE=0, WAIT_LOCK=1, LOCK_STABLE=2, IDLY_RST=3, WAIT_RDY=4, HOLD=5, RUN=6, FAULT=7.
- Transitions:
  - IDLE: next cycle -> WAIT_LOCK.
  - WAIT_LOCK: `idelay_rst`=1, `user_rst`=1. If `lock`=1 and `por`=0 -> LOCK_STABLE, with the stability counter cleared.
  - LOCK_STABLE:
    - Counter increments each cycle while `lock`=1.
    - `lock`=0 -> WAIT_LOCK.
    - Counter = LOCK_STABLE_CYCLES-1 -> IDLY_RST.
  - IDLY_RST: `idelay_rst`=1 for exactly IDELAY_RST_CYCLES cycles, then -> WAIT_RDY with the timeout counter cleared.
  - WAIT_RDY:
    - `idelay_rst`=0.
    - `rdy`=1 -> HOLD.
    - Timeout counter = RDY_TIMEOUT-1 with `rdy`=0:
      - if `retry_cnt` < MAX_RETRY: `retry_cnt`++ and -> IDLY_RST;
      - otherwise -> FAULT.
  - HOLD: `user_rst`=1 for USER_RST_HOLD cycles, then -> RUN. In RUN, `user_rst`=0.
  - RUN: stays until lock loss or POR.
  - FAULT:
    - `fault`=1, `idelay_rst`=0, `user_rst`=1.
    - `clear_fault`=1 -> WAIT_LOCK with `retry_cnt`=0.
- Lock loss or POR:
  - In any state from LOCK_STABLE through RUN, `lock`=0 or `por`=1 -> WAIT_LOCK next cycle.
  - On that transition `user_rst` goes to 1 and `idelay_rst` goes to 1.
  - `retry_cnt` is cleared only on entry to RUN or on `clear_fault`.
- Simultaneous events (priority):
  1. `rst_n`.
  2. Lock loss or POR (overrides timeout, `rdy`, and completion of the hold count).
  3. `clear_fault` (takes effect only in FAULT and ignored elsewhere; in FAULT, lock loss does not leave FAULT).
- Counter width: $clog2(max parameter + 1). Counters never wrap while waiting; they are compared and then cleared on the state change.
- `user_rst` reaches 0 at the earliest LOCK_STABLE_CYCLES + IDELAY_RST_CYCLES + USER_RST_HOLD + 2 + (`rdy` latency) cycles after `lock` rises.

Optional Feature:
- Macro: ROACH_RST_SEQ_LOCK_LOSS_CNT_EN.
- Defined:
  - `lock_loss_cnt` increments by 1 on each transition into WAIT_LOCK caused by `lock`=0 from LOCK_STABLE..RUN.
  - Saturates at 16'hFFFF; cleared only by `rst_n`.
- Undefined: the counter logic is absent and `lock_loss_cnt` is tied to 0.

Decomposition:
- Package `roach_rst_seq_pkg`:
  - state typedef (3-bit enum with the encodings above);
  - `LOCK_LOSS_CNT_W`=16;
  - `RETRY_CNT_W`=4.
- Sub-module `roach_rst_seq_sync`: parameterised-width 2-flop synchroniser with asynchronous active-low reset to 0, instantiated once for the 3-bit input vector.

Test Plan:
- Normal bring-up (LOCK_STABLE_CYCLES=8, IDELAY_RST_CYCLES=4, USER_RST_HOLD=2):
  - Stimulus: release `rst_n`, raise lock at cycle 5, `idelay_rdy` 3 cycles after `idelay_rst` falls.
  - Response: `idelay_rst` high exactly 4 cycles after 8 stable cycles; `user_rst` falls 2 cycles after HOLD entry; `ready`=1; `retry_cnt`=0.
- Lock glitch:
  - Stimulus: drop lock for 1 cycle mid-LOCK_STABLE.
  - Response: `state`=WAIT_LOCK; stability count restarts; `idelay_rst` is not pulsed early.
- Timeout with retries (RDY_TIMEOUT=16, MAX_RETRY=2):
  - Stimulus: hold `idelay_rdy`=0.
  - Response: exactly 3 `idelay_rst` pulses; then `fault`=1, `state`=7, `retry_cnt`=2, `user_rst`=1.
- Fault recovery:
  - Stimulus: pulse `clear_fault` in FAULT, then assert `idelay_rdy`.
  - Response: bring-up reaches RUN; `retry_cnt` cleared to 0.
- Lock loss in RUN:
  - Stimulus: drop lock.
  - Response: `user_rst`=1 and `ready`=0 within 3 cycles of the raw edge (2 synchroniser + 1 register); `lock_loss_cnt` goes 0->1 when the macro is defined, and stays 0 otherwise.
- Asynchronous reset mid-WAIT_RDY:
  - Stimulus: assert `rst_n`=0.
  - Response: outputs take reset values immediately, without a clock edge.
